// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: state set, opcodes,
// datapath select codes and the decode dispatch helper.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        INIT      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        I_EXEC    = 4'd9,
        I_WB      = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        JR        = 4'd13,
        TRAP      = 4'd14
    } ctrlState_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    // States that talk to the unified memory and are therefore watchdogged.
    function automatic logic isMemState(input ctrlState_t s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

    function automatic ctrlState_t dispatchOpcode(input logic [5:0] op, input logic [5:0] fn);
        ctrlState_t next;
        case (op)
            OP_RTYPE: next = (fn == FN_JR) ? JR : R_EXEC;
            OP_LW,
            OP_SW:    next = MEM_ADDR;
            OP_BEQ,
            OP_BNE:   next = BRANCH;
            OP_J,
            OP_JAL:   next = JUMP;
            OP_ADDI,
            OP_ANDI,
            OP_ORI,
            OP_LUI:   next = I_EXEC;
            default:  next = TRAP;
        endcase
        return next;
    endfunction

    function automatic logic [2:0] iTypeAluOp(input logic [5:0] op);
        logic [2:0] aluOp;
        case (op)
            OP_ANDI: aluOp = ALU_AND;
            OP_ORI:  aluOp = ALU_OR;
            OP_LUI:  aluOp = ALU_PASSB;
            default: aluOp = ALU_ADD;
        endcase
        return aluOp;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Stall counter for memory-facing states; flags a timeout when the access
// is still not ready on its MEM_TIMEOUT-th waiting cycle. MEM_TIMEOUT=0 disables it.
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic memActive,
    input  logic memReady,
    output logic timeout
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam bit ENABLE = (MEM_TIMEOUT != 0);

    logic [CW-1:0] count_r;

    // Count stalled cycles; any completion or leaving the memory states restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CW{1'b0}};
        end else if (!memActive || memReady) begin
            count_r <= {CW{1'b0}};
        end else if (count_r != LIMIT) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // A ready on the limit cycle still completes normally, so ready masks the flag.
    always_comb begin
        timeout = 1'b0;
        if (ENABLE && memActive && !memReady && (count_r == LIMIT)) begin
            timeout = 1'b1;
        end else begin
            timeout = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore main control FSM for the multicycle MIPS datapath. Outputs decode from
// the state; only PCWrite/IRWrite are qualified by MemReady and Zero.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] MemToReg,
    output logic [1:0] RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       ExtendSide,
    output logic       Fault
);

    ctrlState_t state_r;
    ctrlState_t nextState_s;
    logic       memActive_s;
    logic       memTimeout_s;
    logic       isLui_s;

    assign memActive_s = isMemState(state_r);
    assign isLui_s     = (Opcode == OP_LUI);

    mem_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) uWatchdog (
        .clk      (clk),
        .reset    (reset),
        .memActive(memActive_s),
        .memReady (MemReady),
        .timeout  (memTimeout_s)
    );

    // State register; async reset drops every output to INIT values at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= INIT;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state and datapath select decode.
    always_comb begin
        nextState_s = state_r;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = MTR_ALUOUT;
        RegDst      = RDST_RT;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALU_ADD;
        PCSource    = PCSRC_ALU;
        ExtendSide  = 1'b0;
        Fault       = 1'b0;

        case (state_r)
            INIT: begin
                nextState_s = FETCH;
            end
            FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                ALUOp    = ALU_ADD;
                PCSource = PCSRC_ALU;
                if (MemReady) begin
                    IRWrite     = 1'b1;
                    PCWrite     = 1'b1;
                    nextState_s = DECODE;
                end else if (memTimeout_s) begin
                    nextState_s = TRAP;
                end else begin
                    nextState_s = FETCH;
                end
            end
            DECODE: begin
                // Speculative branch target into ALUOut while the opcode dispatches.
                ALUSrcB     = SRCB_IMM_SH;
                ALUOp       = ALU_ADD;
                ExtendSide  = isLui_s;
                nextState_s = dispatchOpcode(Opcode, Funct);
            end
            MEM_ADDR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ALUOp       = ALU_ADD;
                nextState_s = (Opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) begin
                    nextState_s = MEM_WB;
                end else if (memTimeout_s) begin
                    nextState_s = TRAP;
                end else begin
                    nextState_s = MEM_READ;
                end
            end
            MEM_WB: begin
                RegWrite    = 1'b1;
                RegDst      = RDST_RT;
                MemToReg    = MTR_MDR;
                nextState_s = FETCH;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    nextState_s = FETCH;
                end else if (memTimeout_s) begin
                    nextState_s = TRAP;
                end else begin
                    nextState_s = MEM_WRITE;
                end
            end
            R_EXEC: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_REG;
                ALUOp       = ALU_FUNCT;
                nextState_s = R_WB;
            end
            R_WB: begin
                RegWrite    = 1'b1;
                RegDst      = RDST_RD;
                MemToReg    = MTR_ALUOUT;
                nextState_s = FETCH;
            end
            I_EXEC: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ALUOp       = iTypeAluOp(Opcode);
                ExtendSide  = isLui_s;
                nextState_s = I_WB;
            end
            I_WB: begin
                // ExtendSide held so the lui result path stays stable through writeback.
                RegWrite    = 1'b1;
                RegDst      = RDST_RT;
                MemToReg    = MTR_ALUOUT;
                ExtendSide  = isLui_s;
                nextState_s = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_REG;
                ALUOp       = ALU_SUB;
                PCSource    = PCSRC_ALUOUT;
                PCWrite     = (Opcode == OP_BNE) ? ~Zero : Zero;
                nextState_s = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                if (Opcode == OP_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = RDST_RA;
                    MemToReg = MTR_PC;
                end else begin
                    RegWrite = 1'b0;
                end
                nextState_s = FETCH;
            end
            JR: begin
                PCWrite     = 1'b1;
                PCSource    = PCSRC_REG;
                nextState_s = FETCH;
            end
            TRAP: begin
                Fault       = 1'b1;
                nextState_s = TRAP;
            end
            default: begin
                Fault       = 1'b1;
                nextState_s = TRAP;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: each stimulus cycle queues
// its hand-computed control word, a negedge monitor pops and compares.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic       ExtendSide, Fault;
    logic [1:0] MemToReg, RegDst, ALUSrcB, PCSource;
    logic [2:0] ALUOp;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .ExtendSide(ExtendSide), .Fault(Fault)
    );

    // Control word bit positions, MSB first:
    // PCWrite IorD MemRead MemWrite IRWrite MemToReg[2] RegDst[2] RegWrite
    // ALUSrcA ALUSrcB[2] ALUOp[3] PCSource[2] ExtendSide Fault
    localparam logic [19:0] PCW      = 20'h80000;
    localparam logic [19:0] IORD     = 20'h40000;
    localparam logic [19:0] MR       = 20'h20000;
    localparam logic [19:0] MW       = 20'h10000;
    localparam logic [19:0] IRW      = 20'h08000;
    localparam logic [19:0] MTR_MDR  = 20'h02000;
    localparam logic [19:0] MTR_PC   = 20'h04000;
    localparam logic [19:0] RDST_RD  = 20'h00800;
    localparam logic [19:0] RDST_RA  = 20'h01000;
    localparam logic [19:0] RW       = 20'h00400;
    localparam logic [19:0] SRCA     = 20'h00200;
    localparam logic [19:0] SRCB_4   = 20'h00080;
    localparam logic [19:0] SRCB_IMM = 20'h00100;
    localparam logic [19:0] SRCB_SH  = 20'h00180;
    localparam logic [19:0] A_SUB    = 20'h00010;
    localparam logic [19:0] A_AND    = 20'h00020;
    localparam logic [19:0] A_OR     = 20'h00030;
    localparam logic [19:0] A_PB     = 20'h00040;
    localparam logic [19:0] A_FN     = 20'h00070;
    localparam logic [19:0] PCS_AO   = 20'h00004;
    localparam logic [19:0] PCS_J    = 20'h00008;
    localparam logic [19:0] PCS_R    = 20'h0000C;
    localparam logic [19:0] EXT      = 20'h00002;
    localparam logic [19:0] FLT      = 20'h00001;
    localparam logic [19:0] NONE     = 20'h00000;

    localparam logic [19:0] F_GO   = MR | SRCB_4 | PCW | IRW;
    localparam logic [19:0] F_WAIT = MR | SRCB_4;
    localparam logic [19:0] DEC    = SRCB_SH;
    localparam logic [19:0] MADDR  = SRCA | SRCB_IMM;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_0    = 6'b000000;

    typedef struct {
        string       name;
        logic [19:0] exp;
    } sbItem_t;

    sbItem_t     sbQ[$];
    sbItem_t     monItem;
    int          compared;
    int          mismatched;
    logic        checkDrain;
    logic [19:0] actual;

    assign actual = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
                     RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtendSide, Fault};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one control word per cycle, compared away from the rising edge.
    always @(negedge clk) begin
        if (sbQ.size() > 0) begin
            monItem = sbQ.pop_front();
            compared++;
            if (actual !== monItem.exp) begin
                mismatched++;
                $display("FAIL %s: got %05h want %05h", monItem.name, actual, monItem.exp);
            end
        end else if (checkDrain) begin
            compared++;
            checkDrain = 1'b0;
        end
    end

    task automatic cyc(input logic rstN, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [19:0] exp,
                       input string name);
        sbItem_t it;
        @(posedge clk);
        #1;
        reset    = rstN;
        Opcode   = op;
        Funct    = fn;
        Zero     = z;
        MemReady = rdy;
        it.name  = name;
        it.exp   = exp;
        sbQ.push_back(it);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        checkDrain = 1'b0;
        reset      = 1'b0;
        Opcode     = OP_R;
        Funct      = FN_0;
        Zero       = 1'b0;
        MemReady   = 1'b1;

        // Reset and release
        cyc(1'b0, OP_LUI, FN_0, 1'b0, 1'b1, NONE, "reset_hold0");
        cyc(1'b0, OP_LUI, FN_0, 1'b0, 1'b1, NONE, "reset_hold1");
        cyc(1'b1, OP_LUI, FN_0, 1'b0, 1'b1, NONE, "init_release");

        // lui
        cyc(1'b1, OP_LUI, FN_0, 1'b0, 1'b1, F_GO, "lui_fetch");
        cyc(1'b1, OP_LUI, FN_0, 1'b0, 1'b1, DEC | EXT, "lui_decode");
        cyc(1'b1, OP_LUI, FN_0, 1'b0, 1'b1, SRCA | SRCB_IMM | A_PB | EXT, "lui_exec");
        cyc(1'b1, OP_LUI, FN_0, 1'b0, 1'b1, RW | EXT, "lui_wb");

        // branches
        cyc(1'b1, OP_BEQ, FN_0, 1'b0, 1'b1, F_GO, "beq_fetch");
        cyc(1'b1, OP_BEQ, FN_0, 1'b0, 1'b1, DEC, "beq_decode");
        cyc(1'b1, OP_BEQ, FN_0, 1'b0, 1'b1, SRCA | A_SUB | PCS_AO, "beq_z0_branch");
        cyc(1'b1, OP_BNE, FN_0, 1'b0, 1'b1, F_GO, "bne_fetch");
        cyc(1'b1, OP_BNE, FN_0, 1'b0, 1'b1, DEC, "bne_decode");
        cyc(1'b1, OP_BNE, FN_0, 1'b0, 1'b1, SRCA | A_SUB | PCS_AO | PCW, "bne_z0_branch");
        cyc(1'b1, OP_BEQ, FN_0, 1'b1, 1'b1, F_GO, "beq2_fetch");
        cyc(1'b1, OP_BEQ, FN_0, 1'b1, 1'b1, DEC, "beq2_decode");
        cyc(1'b1, OP_BEQ, FN_0, 1'b1, 1'b1, SRCA | A_SUB | PCS_AO | PCW, "beq_z1_branch");

        // lw with three stall cycles
        cyc(1'b1, OP_LW, FN_0, 1'b0, 1'b1, F_GO, "lw_fetch");
        cyc(1'b1, OP_LW, FN_0, 1'b0, 1'b1, DEC, "lw_decode");
        cyc(1'b1, OP_LW, FN_0, 1'b0, 1'b1, MADDR, "lw_addr");
        for (int i = 0; i < 3; i++)
            cyc(1'b1, OP_LW, FN_0, 1'b0, 1'b0, MR | IORD, "lw_read_wait");
        cyc(1'b1, OP_LW, FN_0, 1'b0, 1'b1, MR | IORD, "lw_read_done");
        cyc(1'b1, OP_LW, FN_0, 1'b0, 1'b1, RW | MTR_MDR, "lw_wb");

        // R-type add and jr
        cyc(1'b1, OP_R, FN_ADD, 1'b0, 1'b1, F_GO, "add_fetch");
        cyc(1'b1, OP_R, FN_ADD, 1'b0, 1'b1, DEC, "add_decode");
        cyc(1'b1, OP_R, FN_ADD, 1'b0, 1'b1, SRCA | A_FN, "add_exec");
        cyc(1'b1, OP_R, FN_ADD, 1'b0, 1'b1, RW | RDST_RD, "add_wb");
        cyc(1'b1, OP_R, FN_JR, 1'b0, 1'b1, F_GO, "jr_fetch");
        cyc(1'b1, OP_R, FN_JR, 1'b0, 1'b1, DEC, "jr_decode");
        cyc(1'b1, OP_R, FN_JR, 1'b0, 1'b1, PCW | PCS_R, "jr_exec");

        // jal and j
        cyc(1'b1, OP_JAL, FN_0, 1'b0, 1'b1, F_GO, "jal_fetch");
        cyc(1'b1, OP_JAL, FN_0, 1'b0, 1'b1, DEC, "jal_decode");
        cyc(1'b1, OP_JAL, FN_0, 1'b0, 1'b1, PCW | PCS_J | RW | RDST_RA | MTR_PC, "jal_jump");
        cyc(1'b1, OP_J, FN_0, 1'b0, 1'b1, F_GO, "j_fetch");
        cyc(1'b1, OP_J, FN_0, 1'b0, 1'b1, DEC, "j_decode");
        cyc(1'b1, OP_J, FN_0, 1'b0, 1'b1, PCW | PCS_J, "j_jump");

        // MemReady arriving on the watchdog limit cycle wins (andi)
        for (int i = 0; i < 3; i++)
            cyc(1'b1, OP_ANDI, FN_0, 1'b0, 1'b0, F_WAIT, "andi_fetch_wait");
        cyc(1'b1, OP_ANDI, FN_0, 1'b0, 1'b1, F_GO, "andi_fetch_at_limit");
        cyc(1'b1, OP_ANDI, FN_0, 1'b0, 1'b1, DEC, "andi_decode");
        cyc(1'b1, OP_ANDI, FN_0, 1'b0, 1'b1, SRCA | SRCB_IMM | A_AND, "andi_exec");
        cyc(1'b1, OP_ANDI, FN_0, 1'b0, 1'b1, RW, "andi_wb");

        // ori and addi
        cyc(1'b1, OP_ORI, FN_0, 1'b0, 1'b1, F_GO, "ori_fetch");
        cyc(1'b1, OP_ORI, FN_0, 1'b0, 1'b1, DEC, "ori_decode");
        cyc(1'b1, OP_ORI, FN_0, 1'b0, 1'b1, SRCA | SRCB_IMM | A_OR, "ori_exec");
        cyc(1'b1, OP_ORI, FN_0, 1'b0, 1'b1, RW, "ori_wb");
        cyc(1'b1, OP_ADDI, FN_0, 1'b0, 1'b1, F_GO, "addi_fetch");
        cyc(1'b1, OP_ADDI, FN_0, 1'b0, 1'b1, DEC, "addi_decode");
        cyc(1'b1, OP_ADDI, FN_0, 1'b0, 1'b1, SRCA | SRCB_IMM, "addi_exec");
        cyc(1'b1, OP_ADDI, FN_0, 1'b0, 1'b1, RW, "addi_wb");

        // sw with one stall
        cyc(1'b1, OP_SW, FN_0, 1'b0, 1'b1, F_GO, "sw_fetch");
        cyc(1'b1, OP_SW, FN_0, 1'b0, 1'b1, DEC, "sw_decode");
        cyc(1'b1, OP_SW, FN_0, 1'b0, 1'b1, MADDR, "sw_addr");
        cyc(1'b1, OP_SW, FN_0, 1'b0, 1'b0, MW | IORD, "sw_write_wait");
        cyc(1'b1, OP_SW, FN_0, 1'b0, 1'b1, MW | IORD, "sw_write_done");

        // reset asserted mid MEM_WRITE
        cyc(1'b1, OP_SW, FN_0, 1'b0, 1'b1, F_GO, "sw2_fetch");
        cyc(1'b1, OP_SW, FN_0, 1'b0, 1'b1, DEC, "sw2_decode");
        cyc(1'b1, OP_SW, FN_0, 1'b0, 1'b1, MADDR, "sw2_addr");
        cyc(1'b1, OP_SW, FN_0, 1'b0, 1'b0, MW | IORD, "sw2_write_wait");
        cyc(1'b0, OP_SW, FN_0, 1'b0, 1'b0, NONE, "sw2_reset_mid_write");
        cyc(1'b1, OP_SW, FN_0, 1'b0, 1'b1, NONE, "sw2_init");

        // illegal opcode traps
        cyc(1'b1, OP_BAD, FN_0, 1'b0, 1'b1, F_GO, "bad_fetch");
        cyc(1'b1, OP_BAD, FN_0, 1'b0, 1'b1, DEC, "bad_decode");
        cyc(1'b1, OP_BAD, FN_0, 1'b0, 1'b1, FLT, "bad_trap");
        cyc(1'b1, OP_LW, FN_0, 1'b0, 1'b1, FLT, "bad_trap_sticky");
        cyc(1'b0, OP_LW, FN_0, 1'b0, 1'b0, NONE, "bad_reset");
        cyc(1'b1, OP_LW, FN_0, 1'b0, 1'b0, NONE, "to_init");

        // fetch watchdog timeout with MemReady stuck low
        for (int i = 0; i < 4; i++)
            cyc(1'b1, OP_LW, FN_0, 1'b0, 1'b0, F_WAIT, "to_fetch_wait");
        cyc(1'b1, OP_LW, FN_0, 1'b0, 1'b0, FLT, "to_trap");
        cyc(1'b1, OP_LW, FN_0, 1'b0, 1'b1, FLT, "to_trap_ready1");
        cyc(1'b1, OP_LW, FN_0, 1'b0, 1'b1, FLT, "to_trap_ready2");
        cyc(1'b0, OP_LW, FN_0, 1'b0, 1'b1, NONE, "to_reset");

        @(negedge clk);
        #1;
        if (sbQ.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sbQ.size());
            mismatched++;
        end
        checkDrain = 1'b1;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
